// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO, one shift-add or restoring-divide step per bit.
module muldiv_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             rd_req,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic             div_by_zero
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [2:0] {IDLE, PREP, RUN, FIX, DONE} state_t;
  state_t               state;
  logic [1:0]           op_r;
  logic [WIDTH-1:0]     a_r, b_r, m;
  logic                 sign_a, sign_b;
  logic [2*WIDTH-1:0]   acc;
  logic [CW-1:0]        cnt;
  logic                 sa, sb;
  logic [WIDTH-1:0]     mag_a, mag_b, quot, rem;
  logic [WIDTH:0]       sum;
  logic [WIDTH+1:0]     diff;
  logic [2*WIDTH-1:0]   prod;
  // 0x80000000 negates to itself, which is exactly its unsigned magnitude 2^31
  assign sa    = op_r[0] & a_r[WIDTH-1];
  assign sb    = op_r[0] & b_r[WIDTH-1];
  assign mag_a = sa ? -a_r : a_r;
  assign mag_b = sb ? -b_r : b_r;
  assign sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, m};
  // remainder is shifted together with the quotient MSB, so the trial needs one extra bit
  assign diff  = {1'b0, acc[2*WIDTH-1:WIDTH-1]} - {2'b0, m};
  assign prod  = (sign_a ^ sign_b) ? -acc : acc;
  assign quot  = (sign_a ^ sign_b) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign rem   = sign_a ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  assign stall = busy & (rd_req | start);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      op_r        <= '0;
      a_r         <= '0;
      b_r         <= '0;
      m           <= '0;
      sign_a      <= 1'b0;
      sign_b      <= 1'b0;
      acc         <= '0;
      cnt         <= '0;
      hi          <= '0;
      lo          <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            op_r  <= op;
            a_r   <= src_a;
            b_r   <= src_b;
            busy  <= 1'b1;
            state <= PREP;
          end else state <= IDLE;
        end
        PREP: begin
          sign_a <= sa;
          sign_b <= sb;
          cnt    <= '0;
          m      <= op_r[1] ? mag_b : mag_a;
          acc    <= {{WIDTH{1'b0}}, op_r[1] ? mag_a : mag_b};
          if (op_r[1] && b_r == '0) begin
            hi          <= a_r;
            lo          <= '1;
            done        <= 1'b1;
            div_by_zero <= 1'b1;
            busy        <= 1'b0;
            state       <= DONE;
          end else state <= RUN;
        end
        RUN: begin
          cnt <= cnt + 1'b1;
          acc <= op_r[1] ? (diff[WIDTH+1] ? {acc[2*WIDTH-2:0], 1'b0} : {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1})
                         : (acc[0] ? {sum, acc[WIDTH-1:1]} : {1'b0, acc[2*WIDTH-1:1]});
          if (cnt == CW'(WIDTH-1)) state <= FIX;
        end
        FIX: begin
          {hi, lo} <= op_r[1] ? {rem, quot} : prod;
          done     <= 1'b1;
          busy     <= 1'b0;
          state    <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
- Iterative multiply/divide sequencer for the single-cycle CPU core; it executes MULT, MULTU, DIV and DIVU.
- It owns the HI/LO registers and runs a 32-step shift-add / restoring-divide datapath under a small FSM.
- It stalls the pipeline when MFHI/MFLO, or a new mult/div op, arrives while an operation is in flight.
- Results reach memory through the core's normal store path, where the mult/div test bench checks them.

Parameters:
- WIDTH, 32, operand width; also the iteration count (one step per bit).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request a new op; sampled only in IDLE or DONE.
- op  in  2  operation: 00=MULTU, 01=MULT, 10=DIVU, 11=DIV; captured with start.
- src_a  in  WIDTH  rs operand (multiplicand or dividend).
- src_b  in  WIDTH  rt operand (multiplier or divisor).
- rd_req  in  1  CPU is executing MFHI or MFLO this cycle.
- hi  out  WIDTH  HI register (upper product or remainder).
- lo  out  WIDTH  LO register (lower product or quotient).
- busy  out  1  high in PREP, RUN and FIX.
- stall  out  1  equals busy & (rd_req | start); the CPU holds its PC and instruction while this is high.
- done  out  1  one-cycle pulse when hi/lo update.
- div_by_zero  out  1  one-cycle pulse with done on DIV or DIVU when src_b=0.

Behaviour:
- Reset values: state=IDLE; hi=0, lo=0, busy=0, stall=0, done=0, div_by_zero=0; iteration counter=0. Reset asserted mid-operation aborts it immediately, and hi/lo go to 0.
- FSM states: IDLE, PREP, RUN, FIX, DONE.
- IDLE or DONE, start=1: capture op, src_a and src_b, then go to PREP. Otherwise DONE returns to IDLE.
- PREP (1 cycle):
  - Signed ops: record sign_a and sign_b, convert both operands to magnitudes; 0x80000000 stays 0x80000000, treated as unsigned 2^31.
  - Unsigned ops: sign flags are 0.
  - Load a 2*WIDTH accumulator; clear the counter.
  - Divide with src_b=0: go straight to DONE, write lo=0xFFFFFFFF and hi=src_a (raw), pulse div_by_zero. Otherwise go to RUN.
- RUN (exactly WIDTH cycles, counter 0..WIDTH-1, then FIX):
  - Multiply: if the accumulator LSB is 1, add the multiplicand magnitude to the upper half with carry, then shift right 1.
  - Divide (restoring): shift the {rem,quot} pair left 1, trial-subtract the divisor magnitude from rem; if there is no borrow, keep the difference and set the quot LSB to 1.
- FIX (1 cycle):
  - Multiply: if sign_a^sign_b, take the 2*WIDTH two's complement of the product.
  - Divide: quotient is negated if sign_a^sign_b; remainder is negated if sign_a (remainder takes the dividend's sign).
  - Go to DONE.
- DONE: hi/lo are written on the edge entering DONE; done=1 for this cycle only.
- Latency: start sampled at the end of cycle 0 → PREP in cycle 1 → RUN in cycles 2..WIDTH+1 → FIX in cycle WIDTH+2 → DONE in cycle WIDTH+3. For WIDTH=32, done is high in cycle 35. The div-by-zero path has done in cycle 2.
- hi/lo hold their old values during PREP, RUN and FIX. An MFHI/MFLO issued in DONE or IDLE reads the new values with no stall.
- start while busy: ignored, and stall=1. The CPU re-presents it, and it is accepted in DONE, giving a back-to-back restart with no idle cycle.
- start and rd_req both high in DONE: the read sees the just-written hi/lo, and the new op starts.
- Signed DIV of 0x80000000 by 0xFFFFFFFF: lo=0x80000000, hi=0; no exception flag.
- stall is purely combinational from state and inputs. All other outputs are registered.

Test Plan:
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001; done exactly in cycle 35 after the start cycle; busy high in cycles 1–34.
- MULT −3 (0xFFFFFFFD) × 7 → hi=0xFFFFFFFF, lo=0xFFFFFFEB. Then DIV −7 / 2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then DIVU 100 / 7 → lo=14, hi=2.
- DIVU 0x64 / 0 → done and div_by_zero pulse in cycle 2; lo=0xFFFFFFFF, hi=0x00000064. DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
- rd_req held high from cycle 5 during a MULT → stall=1 through cycle 34, stall=0 in cycle 35; hi/lo hold the previous result until cycle 35.
- start re-asserted in cycle 10 with op=DIVU and start held high → stall=1 until DONE, where the new op is accepted; second done arrives 35 cycles later.
- rst pulsed asynchronously mid-RUN (cycle 20) → busy, hi and lo read 0 immediately, state is IDLE; a fresh MULTU 6 × 7 afterwards gives lo=42, hi=0.
